if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction-fetch stage and IF/ID pipeline register of the multistage MIPS datapath. It owns the PC and issues one instruction-memory request at a time over a ready handshake. It delivers `{instr, PC+4}` into the IF/ID register read by the ID stage. Stall requests from the hazard unit and redirects from the EX stage (branch/jump/jr target, the output of the jr-select mux) steer it.

## Interface
- `RESET_PC`, 32'h0000_3000: PC value loaded on reset.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `stall` input 1: hazard unit; hold IF/ID contents and PC.
- `redirect` input 1: EX stage; flush IF/ID and load new PC.
- `redirect_pc` input 32: redirect target; bits [1:0] forced to 0.
- `imem_req` output 1: fetch request valid.
- `imem_addr` output 32: word-aligned fetch address (= PC).
- `imem_ready` input 1: memory returns `imem_rdata` this cycle.
- `imem_rdata` input 32: fetched instruction.
- `IF_ID_instr` output 32: registered instruction (0 = nop when invalid).
- `IF_ID_pc_add_out` output 32: registered PC+4 of that instruction.
- `IF_ID_valid` output 1: IF/ID holds a live instruction.

## Operation
- States: IDLE, FETCH, HOLD, DROP. `imem_req` = 1 in FETCH and DROP only; `imem_addr` = PC.
- IDLE: entered on reset; unconditionally → FETCH next cycle.
- FETCH, `imem_ready`=1:
  - No `stall`: load IF_ID with `imem_rdata`, PC+4, valid=1; PC ← PC+4; stay in FETCH.
  - With `stall`: latch `imem_rdata` and PC+4 into a one-entry skid buffer; PC ← PC+4; → HOLD.
- FETCH, `imem_ready`=0: hold `imem_req`/`imem_addr` stable; IF_ID unchanged unless flushed.
- HOLD: `imem_req`=0; when `stall`=0, move the buffer to IF_ID (valid=1) and → FETCH.
- `stall` with no new data: IF_ID, PC and `IF_ID_valid` are held.
- `redirect` (priority over `stall` in every state):
  - IF_ID_instr ← 0, IF_ID_valid ← 0; PC ← `{redirect_pc[31:2],2'b00}`.
  - FETCH, ready=1: returned data discarded → FETCH.
  - FETCH, ready=0: → DROP.
  - HOLD: buffer discarded → FETCH.
  - DROP: PC updated again; stay in DROP.
- DROP: keeps the old address on `imem_addr` with `imem_req`=1 until `imem_ready`. The returned data is discarded, then → FETCH at the new PC. Only one request is ever outstanding.
- PC+4 wraps modulo 2^32 (32'hFFFF_FFFC → 32'h0000_0000).

## Timing
- Reset values:
  - PC = `RESET_PC`; state = IDLE.
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `IF_ID_instr`=0, `IF_ID_pc_add_out`=0, `IF_ID_valid`=0.
  - Skid buffer cleared.
- First `imem_req` is in the 2nd rising edge after `rst_n` deasserts (IDLE lasts one cycle).
- With `imem_ready` tied high: one instruction per cycle. IF_ID updates on the same edge that samples `imem_ready`=1 (1-cycle latency from request to IF_ID).
- Stall release from HOLD: IF_ID loads on the first edge with `stall`=0; the next request issues the cycle after.
- Redirect: the IF_ID bubble appears on the edge that samples `redirect`. The first request to the target issues the following cycle (FETCH) or after the drain (DROP).
- Asserting `rst_n`=0 mid-transaction aborts immediately. Memory must tolerate an abandoned request.

## Configuration
- `IF_FETCH_PERF_EN` defined: adds outputs `perf_fetched` (32-bit count of IF_ID loads with valid=1) and `perf_flushed` (32-bit count of cycles `redirect` sampled high). Both saturate at 32'hFFFF_FFFF and reset to 0 on `rst_n`.
- Undefined: ports and counters absent; all other behaviour identical.

## Test plan
- Reset, `imem_ready`=1, `imem_rdata`=PC-tagged: `imem_addr` 3000, 3004, 3008 on consecutive cycles. IF_ID_pc_add_out 3004, 3008, 300C; valid=1 from the 2nd edge after release.
- `imem_ready` low 3 cycles at addr 3004: `imem_addr` stable at 3004, IF_ID unchanged; on ready, IF_ID_pc_add_out=3008.
- `stall` high 2 cycles while ready returns 3008's instr: IF_ID frozen at 3008's predecessor with `imem_req`=0. On release, IF_ID holds 3008's instr with pc_add_out=300C, and the next addr is 300C.
- `redirect`=1, `redirect_pc`=32'h0000_3043 while the request to 3010 is pending: IF_ID_valid=0, instr=0. `imem_addr` stays 3010 until ready, the data is dropped, and the next addr is 3040.
- `redirect` and `stall` in the same cycle: flush wins, and the PC becomes the target.
- `RESET_PC`=32'hFFFF_FFFC: 2nd fetch addr 0, and `IF_ID_pc_add_out` of the first instr = 0. With `IF_FETCH_PERF_EN`, `perf_fetched` increments per valid load.

Source files
------------

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: MIPS instruction-fetch stage, PC and IF/ID register with stall skid buffer and redirect drain.
// Define IF_FETCH_PERF_EN to add saturating perf_fetched / perf_flushed counters.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_instr,
    output logic [31:0] IF_ID_pc_add_out,
    output logic        IF_ID_valid
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed
`endif
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;
    state_t      state, state_d;
    logic [31:0] pc, drop_addr, skid_instr, skid_pc, pc_add, target;
    logic        take, fetched, capture;
    assign pc_add  = pc + 32'd4;
    assign target  = redirect_pc & 32'hFFFF_FFFC;
    assign take    = !redirect && state == FETCH && imem_ready;
    assign capture = take && stall;
    assign fetched = (take && !stall) || (!redirect && state == HOLD && !stall);
    always_comb begin
        state_d   = redirect ? ((state == DROP || (state == FETCH && !imem_ready)) ? DROP : FETCH)
                  : state == IDLE  ? FETCH
                  : state == FETCH ? ((imem_ready && stall) ? HOLD : FETCH)
                  : state == HOLD  ? (stall ? HOLD : FETCH)
                  : (imem_ready ? FETCH : DROP);
        imem_req  = state == FETCH || state == DROP;
        imem_addr = state == DROP ? drop_addr : pc;
    end
    // drop_addr freezes the abandoned request's address while pc already points at the target
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            pc               <= RESET_PC;
            drop_addr        <= RESET_PC;
            skid_instr       <= '0;
            skid_pc          <= '0;
            IF_ID_instr      <= '0;
            IF_ID_pc_add_out <= '0;
            IF_ID_valid      <= 1'b0;
        end else begin
            state            <= state_d;
            pc               <= redirect ? target : (state == FETCH && imem_ready) ? pc_add : pc;
            drop_addr        <= (redirect && state == FETCH) ? pc : drop_addr;
            skid_instr       <= capture ? imem_rdata : skid_instr;
            skid_pc          <= capture ? pc_add : skid_pc;
            IF_ID_instr      <= redirect ? 32'd0 : fetched ? (state == HOLD ? skid_instr : imem_rdata) : IF_ID_instr;
            IF_ID_pc_add_out <= fetched ? (state == HOLD ? skid_pc : pc_add) : IF_ID_pc_add_out;
            IF_ID_valid      <= redirect ? 1'b0 : fetched ? 1'b1 : IF_ID_valid;
        end
    end
`ifdef IF_FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            perf_fetched <= (fetched && !(&perf_fetched)) ? perf_fetched + 32'd1 : perf_fetched;
            perf_flushed <= (redirect && !(&perf_flushed)) ? perf_flushed + 32'd1 : perf_flushed;
        end
    end
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed test-plan steps then random stimulus checked against a transaction-level model.
module tb_if_fetch_unit;
    logic        clk = 0, rst_n = 1, stall = 0, redirect = 0, imem_ready = 0;
    logic [31:0] redirect_pc = 0, imem_rdata = 0;
    logic        imem_req, IF_ID_valid, w_req, w_valid;
    logic [31:0] imem_addr, IF_ID_instr, IF_ID_pc_add_out, w_addr, w_instr, w_pca;
`ifdef IF_FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_flushed, w_pf, w_pl;
`endif
    int tests = 0, fails = 0;
    always #5 clk = ~clk;
    if_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .IF_ID_instr(IF_ID_instr), .IF_ID_pc_add_out(IF_ID_pc_add_out), .IF_ID_valid(IF_ID_valid)
`ifdef IF_FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
    );
    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .IF_ID_instr(w_instr), .IF_ID_pc_add_out(w_pca), .IF_ID_valid(w_valid)
`ifdef IF_FETCH_PERF_EN
        , .perf_fetched(w_pf), .perf_flushed(w_pl)
`endif
    );
    // model: started = past the reset cycle, hold = instruction parked in skid, drop = answer to be discarded
    bit          m_started, m_hold, m_drop, m_valid;
    logic [31:0] m_pc, m_drop_addr, m_skid_instr, m_skid_pca, m_instr, m_pca, m_fetched, m_flushed;
    function automatic logic [31:0] tag(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction
    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", name, obs, exp);
        end
    endtask
    task automatic model_reset();
        m_started = 0; m_hold = 0; m_drop = 0; m_valid = 0;
        m_pc = 32'h0000_3000; m_drop_addr = 0; m_skid_instr = 0; m_skid_pca = 0;
        m_instr = 0; m_pca = 0; m_fetched = 0; m_flushed = 0;
    endtask
    task automatic model_edge();
        if (redirect) begin
            m_flushed++;
            if (m_started && !m_hold && !m_drop && !imem_ready) begin
                m_drop = 1;
                m_drop_addr = m_pc;
            end
            m_instr = 0; m_valid = 0; m_hold = 0; m_started = 1;
            m_pc = {redirect_pc[31:2], 2'b00};
        end else if (!m_started) m_started = 1;
        else if (m_hold) begin
            if (!stall) begin
                m_instr = m_skid_instr; m_pca = m_skid_pca; m_valid = 1; m_hold = 0; m_fetched++;
            end
        end else if (m_drop) begin
            if (imem_ready) m_drop = 0;
        end else if (imem_ready) begin
            if (stall) begin
                m_skid_instr = imem_rdata; m_skid_pca = m_pc + 4; m_hold = 1;
            end else begin
                m_instr = imem_rdata; m_pca = m_pc + 4; m_valid = 1; m_fetched++;
            end
            m_pc = m_pc + 4;
        end
    endtask
    task automatic check_all();
        chk("req", {31'd0, imem_req}, {31'd0, m_started && !m_hold});
        chk("addr", imem_addr, m_drop ? m_drop_addr : m_pc);
        chk("instr", IF_ID_instr, m_instr);
        chk("pca", IF_ID_pc_add_out, m_pca);
        chk("valid", {31'd0, IF_ID_valid}, {31'd0, m_valid});
`ifdef IF_FETCH_PERF_EN
        chk("perf_fetched", perf_fetched, m_fetched);
        chk("perf_flushed", perf_flushed, m_flushed);
`endif
    endtask
    task automatic step(input logic st, input logic rd, input logic [31:0] rpc, input logic rdy, input logic [31:0] data);
        stall = st; redirect = rd; redirect_pc = rpc; imem_ready = rdy; imem_rdata = data;
        #1 check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask
    task automatic check_reset();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0000_3000);
        chk("rst_instr", IF_ID_instr, 32'd0);
        chk("rst_pca", IF_ID_pc_add_out, 32'd0);
        chk("rst_valid", {31'd0, IF_ID_valid}, 32'd0);
        chk("rst_wrap_addr", w_addr, 32'hFFFF_FFFC);
    endtask
    initial begin
        #1 rst_n = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset();
        rst_n = 1;
        step(0, 0, 0, 1, 32'hDEAD_BEEF);
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("addr_3000", imem_addr, 32'h0000_3000);
        step(0, 0, 0, 1, tag(32'h3000));
        chk("pca_3004", IF_ID_pc_add_out, 32'h0000_3004);
        chk("valid_first", {31'd0, IF_ID_valid}, 32'd1);
        chk("addr_3004", imem_addr, 32'h0000_3004);
        chk("wrap_pca", w_pca, 32'd0);
        chk("wrap_addr", w_addr, 32'd0);
        repeat (3) begin
            step(0, 0, 0, 0, 32'h1111_1111);
            chk("wait_addr", imem_addr, 32'h0000_3004);
            chk("wait_pca", IF_ID_pc_add_out, 32'h0000_3004);
        end
        step(0, 0, 0, 1, tag(32'h3004));
        chk("pca_3008", IF_ID_pc_add_out, 32'h0000_3008);
        chk("addr_3008", imem_addr, 32'h0000_3008);
        step(1, 0, 0, 1, tag(32'h3008));
        chk("hold_req", {31'd0, imem_req}, 32'd0);
        chk("hold_pca", IF_ID_pc_add_out, 32'h0000_3008);
        step(1, 0, 0, 0, 32'h2222_2222);
        chk("hold_instr", IF_ID_instr, tag(32'h3004));
        step(0, 0, 0, 0, 32'h3333_3333);
        chk("rel_instr", IF_ID_instr, tag(32'h3008));
        chk("rel_pca", IF_ID_pc_add_out, 32'h0000_300C);
        chk("rel_addr", imem_addr, 32'h0000_300C);
        step(0, 0, 0, 1, tag(32'h300C));
        chk("addr_3010", imem_addr, 32'h0000_3010);
        step(0, 1, 32'h0000_3043, 0, 32'h4444_4444);
        chk("flush_valid", {31'd0, IF_ID_valid}, 32'd0);
        chk("flush_instr", IF_ID_instr, 32'd0);
        chk("drop_addr", imem_addr, 32'h0000_3010);
        step(0, 0, 0, 0, 32'h5555_5555);
        chk("drop_addr2", imem_addr, 32'h0000_3010);
        step(0, 0, 0, 1, 32'h6666_6666);
        chk("target_addr", imem_addr, 32'h0000_3040);
        chk("drop_discard", {31'd0, IF_ID_valid}, 32'd0);
        step(0, 0, 0, 1, tag(32'h3040));
        chk("target_pca", IF_ID_pc_add_out, 32'h0000_3044);
        step(1, 1, 32'h0000_3101, 1, 32'h7777_7777);
        chk("rs_valid", {31'd0, IF_ID_valid}, 32'd0);
        chk("rs_addr", imem_addr, 32'h0000_3100);
        chk("rs_req", {31'd0, imem_req}, 32'd1);
        step(0, 0, 0, 1, tag(32'h3100));
        chk("rs_pca", IF_ID_pc_add_out, 32'h0000_3104);
        for (int i = 0; i < 1500; i++) begin
            if (i == 750) begin
                #2 rst_n = 0;
                #1 model_reset();
                check_reset();
                @(negedge clk);
                rst_n = 1;
            end
            step($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0, $urandom,
                 $urandom_range(0, 2) != 0, $urandom);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
